// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Instruction-memory handshake between the fetch stage and instruction memory.
// Only one request is outstanding at a time.
//
// Signals:
//   imem_req    fetch request (driven by the fetch stage)
//   imem_addr   fetch address, equal to the fetch PC (driven by the fetch stage)
//   imem_ready  memory completes the request this cycle (driven by memory)
//   imem_rdata  instruction word, valid when imem_req && imem_ready (driven by memory)
//
// Modports:
//   master  fetch-stage side
//   slave   memory side
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end of the 5-stage MIPS pipeline. This block holds
// the PC and the IF/ID pipeline register. It obeys the hazard-unit enables and
// takes the ID-stage redirect. It talks to instruction memory over a
// single-outstanding req/ready handshake.
//
// States:
//   FETCH    request outstanding at PC
//   HOLD     a returned word waits in the one-entry buffer while the pipe stalls
//   DISCARD  the outstanding request was squashed; its response is dropped
//
// Parameters:
//   RESET_PC    PC loaded on reset
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   PCWrite     hazard-unit PC enable (0 = stall)
//   IF_IDWrite  hazard-unit IF/ID enable (0 = stall)
//   Redirect    taken branch/jump resolved in ID this cycle
//   RedirectPC  redirect target
//   imem        instruction-memory handshake (fetch_stage_if.master)
//   PC_IF       current fetch PC
//   Instr_ID    IF/ID instruction (0 = NOP on bubble)
//   PCPlus4_ID  IF/ID PC+4
//   Valid_ID    IF/ID holds a real instruction
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   stall_cnt   cycles spent in HOLD, wraps modulo 2^32
//   squash_cnt  dropped memory responses, wraps modulo 2^32
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCWrite,
  input  logic                IF_IDWrite,
  input  logic                Redirect,
  input  logic [31:0]         RedirectPC,
  fetch_stage_if.master       imem,
  output logic [31:0]         PC_IF,
  output logic [31:0]         Instr_ID,
  output logic [31:0]         PCPlus4_ID,
  output logic                Valid_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;
  logic [31:0] r_pending;
  logic [31:0] r_instr_id;
  logic [31:0] r_pc4_id;
  logic        r_valid_id;

  logic        w_advance;
  logic        w_complete;
  logic [31:0] w_pc_plus4;
  logic        w_deliver;
  logic [31:0] w_deliver_instr;
  logic [31:0] w_deliver_pc4;

  assign w_advance  = PCWrite & IF_IDWrite;
  assign w_pc_plus4 = r_pc + 32'd4;

  // HOLD never requests, so no completion can occur there.
  assign imem.imem_req  = ~reset & (r_state != S_HOLD);
  assign imem.imem_addr = r_pc;
  assign w_complete     = imem.imem_req & imem.imem_ready;

  // An instruction reaches IF/ID either straight from memory or from the hold
  // buffer. A redirect in the same cycle squashes it.
  assign w_deliver = ~Redirect & w_advance &
                     (((r_state == S_FETCH) & w_complete) | (r_state == S_HOLD));
  assign w_deliver_instr = (r_state == S_HOLD) ? r_buf_instr : imem.imem_rdata;
  assign w_deliver_pc4   = (r_state == S_HOLD) ? r_buf_pc4   : w_pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_buf_instr <= 32'd0;
      r_buf_pc4   <= 32'd0;
      r_pending   <= 32'd0;
      r_instr_id  <= 32'd0;
      r_pc4_id    <= 32'd0;
      r_valid_id  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_complete) begin
            if (Redirect) begin
              r_pc <= RedirectPC;
            end else if (w_advance) begin
              r_pc <= w_pc_plus4;
            end else begin
              r_buf_instr <= imem.imem_rdata;
              r_buf_pc4   <= w_pc_plus4;
              r_state     <= S_HOLD;
            end
          end else if (Redirect) begin
            // The request cannot be withdrawn. Remember the target and
            // throw the response away when it arrives.
            r_pending <= RedirectPC;
            r_state   <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (Redirect) begin
            r_pc    <= RedirectPC;
            r_state <= S_FETCH;
          end else if (w_advance) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (w_complete) begin
            r_pc    <= Redirect ? RedirectPC : r_pending;
            r_state <= S_FETCH;
          end else if (Redirect) begin
            r_pending <= RedirectPC;
          end
        end
        default: r_state <= S_FETCH;
      endcase

      // IF/ID: redirect beats stall, stall beats load/bubble.
      if (Redirect) begin
        r_valid_id <= 1'b0;
        r_instr_id <= 32'd0;
      end else if (IF_IDWrite) begin
        if (w_deliver) begin
          r_valid_id <= 1'b1;
          r_instr_id <= w_deliver_instr;
          r_pc4_id   <= w_deliver_pc4;
        end else begin
          r_valid_id <= 1'b0;
          r_instr_id <= 32'd0;
        end
      end
    end
  end

  assign PC_IF      = r_pc;
  assign Instr_ID   = r_instr_id;
  assign PCPlus4_ID = r_pc4_id;
  assign Valid_ID   = r_valid_id;

`ifdef FETCH_PERF_CNT_EN
  logic        w_drop;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_squash_cnt;

  // A response is lost when it is squashed on arrival, when a buffered word
  // is dropped, or when a squashed fetch finally completes.
  assign w_drop = ((r_state == S_FETCH)   & w_complete & Redirect) |
                  ((r_state == S_HOLD)    & Redirect) |
                  ((r_state == S_DISCARD) & w_complete);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= 32'd0;
      r_squash_cnt <= 32'd0;
    end else begin
      if (r_state == S_HOLD) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_drop)            r_squash_cnt <= r_squash_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] PC_IF;
  logic [31:0] Instr_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] squash_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .IF_IDWrite (IF_IDWrite),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .imem       (bus),
    .PC_IF      (PC_IF),
    .Instr_ID   (Instr_ID),
    .PCPlus4_ID (PCPlus4_ID),
    .Valid_ID   (Valid_ID)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .squash_cnt (squash_cnt)
`endif
  );

  // Instruction memory contents: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0] ^ a[31:16], a[15:0]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_iaddr;
  } vec_t;

  function automatic vec_t mk(input logic pcw, input logic ifw, input logic rd,
                              input logic [31:0] rpc, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic vld, input logic [31:0] ia);
    vec_t v;
    v.pcw = pcw; v.ifw = ifw; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.exp_req = req; v.exp_addr = addr; v.exp_vld = vld; v.exp_iaddr = ia;
    return v;
  endfunction

  task automatic drive(input logic r, input logic pcw, input logic ifw, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    reset          = r;
    PCWrite        = pcw;
    IF_IDWrite     = ifw;
    Redirect       = rd;
    RedirectPC     = rpc;
    bus.imem_ready = rdy;
  endtask

  task automatic check_id(input string tag, input logic vld, input logic [31:0] ia);
    check({tag, " Valid_ID"}, 32'(Valid_ID), 32'(vld));
    check({tag, " Instr_ID"}, Instr_ID, vld ? mem_word(ia) : 32'd0);
    if (vld) check({tag, " PCPlus4_ID"}, PCPlus4_ID, ia + 32'd4);
  endtask

  vec_t tbl[25];

  // random-phase model state
  logic [31:0] exp_pc;
  logic        busy;
  int          wcnt;
  logic [31:0] taddr;
  int          stall_left;
  logic        st, rd, rdy, cyc_ifw, cyc_rd;
  logic [31:0] rpc, cyc_rpc;
  logic        pv;
  logic [31:0] pi, pp;
  int          deliveries, completions, hold_cycles;

  initial begin
    tbl[0]  = mk(1,1,0,0,1,            1, BASE,          0, 0);
    tbl[1]  = mk(1,1,0,0,1,            1, BASE+4,        1, BASE);
    tbl[2]  = mk(1,1,0,0,1,            1, BASE+8,        1, BASE+4);
    tbl[3]  = mk(1,1,1,32'h0,1,        1, BASE+12,       1, BASE+8);
    tbl[4]  = mk(1,1,0,0,0,            1, 32'h0,         0, 0);
    tbl[5]  = mk(1,1,0,0,0,            1, 32'h0,         0, 0);
    tbl[6]  = mk(1,1,0,0,1,            1, 32'h0,         0, 0);
    tbl[7]  = mk(1,1,0,0,0,            1, 32'h4,         1, 32'h0);
    tbl[8]  = mk(1,1,0,0,0,            1, 32'h4,         0, 0);
    tbl[9]  = mk(1,1,0,0,1,            1, 32'h4,         0, 0);
    tbl[10] = mk(0,0,0,0,1,            1, 32'h8,         1, 32'h4);
    tbl[11] = mk(1,1,0,0,0,            0, 32'h8,         1, 32'h4);
    tbl[12] = mk(1,1,0,0,1,            1, 32'hC,         1, 32'h8);
    tbl[13] = mk(1,1,1,32'h100,0,      1, 32'h10,        1, 32'hC);
    tbl[14] = mk(1,1,0,0,0,            1, 32'h10,        0, 0);
    tbl[15] = mk(1,1,0,0,1,            1, 32'h10,        0, 0);
    tbl[16] = mk(1,1,0,0,1,            1, 32'h100,       0, 0);
    tbl[17] = mk(1,1,1,32'h200,0,      1, 32'h104,       1, 32'h100);
    tbl[18] = mk(1,1,1,32'h300,0,      1, 32'h104,       0, 0);
    tbl[19] = mk(1,1,0,0,1,            1, 32'h104,       0, 0);
    tbl[20] = mk(1,1,0,0,1,            1, 32'h300,       0, 0);
    tbl[21] = mk(1,1,1,32'hFFFF_FFFC,1,1, 32'h304,       1, 32'h300);
    tbl[22] = mk(1,1,0,0,1,            1, 32'hFFFF_FFFC, 0, 0);
    tbl[23] = mk(1,1,0,0,1,            1, 32'h0,         1, 32'hFFFF_FFFC);
    tbl[24] = mk(1,1,0,0,1,            1, 32'h4,         1, 32'h0);

    // Reset values
    drive(1, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 0, 1);
    @(negedge clk);
    check("reset imem_req",   32'(bus.imem_req), 32'd0);
    check("reset PC_IF",      PC_IF,      BASE);
    check("reset Valid_ID",   32'(Valid_ID), 32'd0);
    check("reset Instr_ID",   Instr_ID,   32'd0);
    check("reset PCPlus4_ID", PCPlus4_ID, 32'd0);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 25; i++) begin
      drive(0, tbl[i].pcw, tbl[i].ifw, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      @(negedge clk);
      check($sformatf("tbl%0d imem_req", i),  32'(bus.imem_req), 32'(tbl[i].exp_req));
      check($sformatf("tbl%0d imem_addr", i), bus.imem_addr, tbl[i].exp_addr);
      check_id($sformatf("tbl%0d", i), tbl[i].exp_vld, tbl[i].exp_iaddr);
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_CNT_EN
    check("tbl squash_cnt", squash_cnt, 32'd4);
    check("tbl stall_cnt",  stall_cnt,  32'd1);
`endif

    // Reset in the middle of an outstanding fetch
    drive(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    check("midreset req before", 32'(bus.imem_req), 32'd1);
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 0, 0);
    @(negedge clk);
    check("midreset req during", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #1;

    // Load-use stall of 3 cycles with zero-wait memory (cycles 3..5)
    for (int i = 0; i < 13; i++) begin
      logic        s, ev, er;
      logic [31:0] ea, ei;
      s  = (i >= 3 && i <= 5);
      drive(0, !s, !s, 0, 0, 1);
      er = !(i >= 4 && i <= 6);
      ea = (i <= 3) ? BASE + 32'(4*i) : (i <= 6) ? BASE + 32'hC : BASE + 32'(4*(i-3));
      ev = (i >= 1);
      ei = (i <= 3) ? BASE + 32'(4*(i-1)) : (i <= 6) ? BASE + 32'h8 : BASE + 32'(4*(i-4));
      @(negedge clk);
      if (i == 0) check("postreset PCPlus4_ID", PCPlus4_ID, 32'd0);
      check($sformatf("kstall%0d imem_req", i),  32'(bus.imem_req), 32'(er));
      check($sformatf("kstall%0d imem_addr", i), bus.imem_addr, ea);
      check_id($sformatf("kstall%0d", i), ev, ei);
      @(posedge clk); #1;
    end

    // Randomized run against a program-order model
    drive(1, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    exp_pc = BASE; busy = 1'b0; wcnt = 0; taddr = 0; stall_left = 0;
    deliveries = 0; completions = 0; hold_cycles = 0;
    pv = Valid_ID; pi = Instr_ID; pp = PCPlus4_ID;
    for (int c = 0; c < 3000; c++) begin
      if (stall_left > 0) begin
        stall_left--; st = 1'b1;
      end else if ($urandom_range(9) == 0) begin
        stall_left = $urandom_range(3); st = 1'b1;
      end else st = 1'b0;
      rd  = ($urandom_range(11) == 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
      drive(0, !st, !st, rd, rpc, 0);
      #1;
      rdy = 1'b0;
      if (bus.imem_req) begin
        if (!busy) begin
          busy = 1'b1; wcnt = $urandom_range(2); taddr = bus.imem_addr;
        end else check("rnd addr stable", bus.imem_addr, taddr);
        rdy = (wcnt == 0);
      end else begin
        hold_cycles++;
      end
      bus.imem_ready = rdy;
      cyc_ifw = !st; cyc_rd = rd; cyc_rpc = rpc;
      @(negedge clk);
      check("rnd PC_IF==imem_addr", PC_IF, bus.imem_addr);
      if (bus.imem_req && rdy) begin
        busy = 1'b0; completions++;
      end else if (bus.imem_req) wcnt--;
      @(posedge clk); #1;
      if (cyc_rd) begin
        check("rnd redirect Valid_ID", 32'(Valid_ID), 32'd0);
        check("rnd redirect Instr_ID", Instr_ID, 32'd0);
        exp_pc = cyc_rpc;
      end else if (!cyc_ifw) begin
        check("rnd stall Valid_ID",   32'(Valid_ID), 32'(pv));
        check("rnd stall Instr_ID",   Instr_ID,   pi);
        check("rnd stall PCPlus4_ID", PCPlus4_ID, pp);
      end else if (Valid_ID) begin
        check("rnd Instr_ID",   Instr_ID,   mem_word(exp_pc));
        check("rnd PCPlus4_ID", PCPlus4_ID, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        check("rnd bubble Instr_ID", Instr_ID, 32'd0);
      end
      pv = Valid_ID; pi = Instr_ID; pp = PCPlus4_ID;
    end
    check("rnd throughput", 32'(deliveries >= 300), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("rnd stall_cnt",  stall_cnt, 32'(hold_cycles));
    check("rnd squash_cnt", squash_cnt,
          32'(completions - deliveries - (bus.imem_req ? 0 : 1)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register, and consumes the hazard controls (PCWrite, IF_IDWrite) plus the ID-stage branch/jump redirect. It talks to instruction memory over a single-outstanding req/ready handshake, so it tolerates multi-cycle memory. A one-entry hold buffer absorbs an instruction that returns while the pipeline is stalled. It also drops responses belonging to squashed fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- PCWrite  in  1  hazard-unit PC enable; 0 = stall.
- IF_IDWrite  in  1  hazard-unit IF/ID enable; 0 = stall.
- Redirect  in  1  taken branch/jump resolved in ID this cycle.
- RedirectPC  in  32  target address, valid when Redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the PC.
- imem_ready  in  1  memory completes the request this cycle.
- imem_rdata  in  32  instruction, valid when imem_req && imem_ready.
- PC_IF  out  32  current fetch PC.
- Instr_ID  out  32  IF/ID instruction.
- PCPlus4_ID  out  32  IF/ID PC+4.
- Valid_ID  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- advance = PCWrite & IF_IDWrite. A completion is any cycle with imem_req && imem_ready.
- States are FETCH, HOLD and DISCARD.
- imem_req = 1 in FETCH and DISCARD, 0 in HOLD and whenever reset=1.
- FETCH:
  - On completion with Redirect=1: drop the data; PC <= RedirectPC; stay in FETCH.
  - On completion with advance=1: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4.
  - On completion with advance=0: hold buffer <= {imem_rdata, PC+4}; PC unchanged; go to HOLD.
  - With no completion and Redirect=1: pending <= RedirectPC; go to DISCARD.
  - With no completion and Redirect=0: stay in FETCH.
- HOLD:
  - Redirect=1: drop the buffer; PC <= RedirectPC; go to FETCH.
  - advance=1: IF/ID <= buffer with valid=1; PC <= PC+4; go to FETCH.
  - Otherwise: hold.
- DISCARD:
  - The request stays asserted at the old address.
  - A further Redirect overwrites pending (last wins).
  - On completion: drop the data; PC <= pending, or RedirectPC if Redirect=1 in that same cycle; go to FETCH.
- IF/ID register, in priority order:
  1. Redirect=1 forces Valid_ID <= 0 and Instr_ID <= 0 (NOP).
  2. IF_IDWrite=0 holds the register.
  3. IF_IDWrite=1 with no instruction delivered loads a bubble (Valid_ID <= 0, Instr_ID <= 0).
- Redirect has priority over a stall. ID must not assert Redirect for a branch that is itself load-use stalled; if it does, Redirect still wins.
- Arithmetic: PC+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0. PC[1:0] is not checked.

## Timing
- Reset values: state FETCH, PC=RESET_PC, Valid_ID=0, Instr_ID=0, PCPlus4_ID=0, buffer cleared, pending=0, imem_req=0.
- The first request is issued in the first cycle with reset=0.
- Zero-wait memory (imem_ready held at 1): one instruction per cycle. Instr_ID is visible one cycle after its completion cycle.
- N wait cycles per fetch: N+1 cycles per instruction, with bubbles (Valid_ID=0) inserted into ID.
- imem_addr is stable from the cycle imem_req rises until the completion cycle inclusive; PC changes only at completion or in HOLD.
- Reset mid-transaction: everything returns to the reset values next cycle. An outstanding memory response is not tracked, so the memory must also reset.
- A load-use stall lasting K cycles delays the next instruction by exactly K cycles, with no loss or duplication.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds output ports stall_cnt (32) and squash_cnt (32), both reset to 0 and wrapping modulo 2^32.
  - stall_cnt increments every cycle the block is in HOLD.
  - squash_cnt increments once per dropped response, whether dropped in FETCH, HOLD or DISCARD.
- FETCH_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC=32'h0040_0000 and imem_ready=1 -> imem_addr sequence 0x400000, 0x400004, 0x400008; Valid_ID first high one cycle after the first completion.
- imem_ready low for 2 cycles per fetch -> addr stable while waiting; Valid_ID pattern 0,0,1 repeating; no instruction lost.
- PCWrite=IF_IDWrite=0 for 1 cycle while the word at 0x8 returns -> HOLD entered; the word at 0x8 reaches Instr_ID exactly once after the release; imem_req=0 during HOLD.
- Redirect to 0x100 while a fetch of 0x10 is waiting -> the 0x10 data is dropped; next imem_addr=0x100; Valid_ID=0 during the squash; squash_cnt=1 if enabled.
- Redirect to 0x200 then 0x300 on consecutive DISCARD cycles -> fetch resumes at 0x300.
- PC=32'hFFFF_FFFC completes -> PCPlus4_ID=0 and the next imem_addr=0.
